// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO egress to valid/ready stream adapter.
package fifo_stream_reader_pkg;

    localparam int BEAT_COUNT_WIDTH_C = 32;
    localparam int PKT_COUNT_WIDTH_C  = 16;
    localparam int BUFFER_DEPTH_C     = 2;

endpackage

// File: rtl/fifo_stream_reader_buffer.sv
// Two-entry head-first output buffer; the head entry drives the stream data directly.
module fifo_stream_reader_buffer
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH_P = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_WIDTH_P-1:0] push_data_i,
    output logic [DATA_WIDTH_P-1:0] head_data_o,
    output logic                    head_valid_o,
    output logic [1:0]              occupancy_o,
    output logic [1:0]              occupancy_next_o
);

    logic [DATA_WIDTH_P-1:0] head_q, head_d;
    logic [DATA_WIDTH_P-1:0] tail_q, tail_d;
    logic [1:0]              occ_q, occ_d;
    logic                    valid_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_data_i;
                else               tail_d = push_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Head advances and the new word lands behind it.
                if (occ_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != 2'd0);
        end
    end

    assign head_data_o      = head_q;
    assign head_valid_o     = valid_q;
    assign occupancy_o      = occ_q;
    assign occupancy_next_o = occ_d;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO egress port into a valid/ready stream at full rate.
// Optional m_last generation is enabled by defining FIFO_STREAM_READER_LAST_EN.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH_P    = -1,
    parameter int PACKET_LENGTH_P = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          egr_enable,
    input  logic [DATA_WIDTH_P-1:0]       egr_data,
    input  logic                          egr_empty,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH_P-1:0]       m_data,
    output logic                          m_last,
    output logic [BEAT_COUNT_WIDTH_C-1:0] sr_beat_count
);

    logic                          pop;
    logic                          capture;
    logic [1:0]                    occupancy;
    logic [1:0]                    occupancy_next;
    logic [2:0]                    committed;
    logic [1:0]                    inflight_q, inflight_d;
    logic [BEAT_COUNT_WIDTH_C-1:0] beat_q;

    assign pop     = m_valid && m_ready;
    assign capture = (inflight_q != 2'd0);

    // Slots already claimed by buffered or requested words, net of this cycle's pop.
    assign committed  = 3'(occupancy) + 3'(inflight_q) - 3'(pop);
    assign egr_enable = rst_n && !egr_empty && (committed < 3'(BUFFER_DEPTH_C));
    assign inflight_d = inflight_q + 2'(egr_enable) - 2'(capture);

    fifo_stream_reader_buffer #(
        .DATA_WIDTH_P(DATA_WIDTH_P)
    ) u_buffer (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_i           (capture),
        .pop_i            (pop),
        .push_data_i      (egr_data),
        .head_data_o      (m_data),
        .head_valid_o     (m_valid),
        .occupancy_o      (occupancy),
        .occupancy_next_o (occupancy_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 2'd0;
            beat_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (pop) beat_q <= beat_q + 1'b1;
        end
    end

    assign sr_beat_count = beat_q;

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam logic [PKT_COUNT_WIDTH_C-1:0] PKT_LAST_C = PKT_COUNT_WIDTH_C'(PACKET_LENGTH_P - 1);

    logic [PKT_COUNT_WIDTH_C-1:0] pkt_q, pkt_d;
    logic                         last_q;

    // pkt_q is the beat index of the current head word.
    always_comb begin
        pkt_d = pkt_q;
        if (pop) pkt_d = (pkt_q == PKT_LAST_C) ? '0 : pkt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            pkt_q  <= pkt_d;
            last_q <= (occupancy_next != 2'd0) && (pkt_d == PKT_LAST_C);
        end
    end

    assign m_last = last_q;
`else
    assign m_last = 1'b0;
`endif

endmodule
